// File: rtl/circle_point_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : circle_point_gen
// Description : Streams, in raster order, every grid point the laser datapath
//               classifies as inside the circle around a given center.
// Revision    : 1.0 - initial release
// ============================================================================
module circle_point_gen #(
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               done,
    output logic [5:0]         pt_count
);

    localparam int CAND_W = COORD_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [3:0] OFS_MIN = -4'sd4;
    localparam logic signed [3:0] OFS_MAX = 4'sd4;

    logic [1:0]               r_state;
    logic [COORD_W-1:0]       r_cx;
    logic [COORD_W-1:0]       r_cy;
    logic signed [3:0]        r_ox;
    logic signed [3:0]        r_oy;
    logic                     r_busy;
    logic                     r_out_valid;
    logic [COORD_W-1:0]       r_out_x;
    logic [COORD_W-1:0]       r_out_y;
    logic                     r_done;
    logic [5:0]               r_pt_count;

    logic signed [3:0]        w_neg_ox;
    logic signed [3:0]        w_neg_oy;
    logic [2:0]               w_ax;
    logic [2:0]               w_ay;
    logic [3:0]               w_sum;
    logic                     w_rule;
    logic signed [CAND_W-1:0] w_cand_x;
    logic signed [CAND_W-1:0] w_cand_y;
    logic                     w_in_grid;
    logic                     w_emit;
    logic                     w_slot_free;
    logic                     w_last;

    assign w_neg_ox = -r_ox;
    assign w_neg_oy = -r_oy;
    assign w_ax     = r_ox[3] ? w_neg_ox[2:0] : r_ox[2:0];
    assign w_ay     = r_oy[3] ? w_neg_oy[2:0] : r_oy[2:0];
    assign w_sum    = {1'b0, w_ax} + {1'b0, w_ay};

    // Diamond of radius 4 plus the eight knight-like (2,3)/(3,2) corners.
    assign w_rule = (w_sum <= 4'd4)
                 || (w_ax == 3'd2 && w_ay == 3'd3)
                 || (w_ax == 3'd3 && w_ay == 3'd2);

    assign w_cand_x = $signed({2'b00, r_cx}) + $signed({{(CAND_W-4){r_ox[3]}}, r_ox});
    assign w_cand_y = $signed({2'b00, r_cy}) + $signed({{(CAND_W-4){r_oy[3]}}, r_oy});

    // Negative or past-the-edge results both show up in the two guard bits.
    assign w_in_grid = (w_cand_x[CAND_W-1:COORD_W] == 2'b00)
                    && (w_cand_y[CAND_W-1:COORD_W] == 2'b00);

    assign w_emit      = w_rule && w_in_grid;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_last      = (r_ox == OFS_MAX) && (r_oy == OFS_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cx        <= '0;
            r_cy        <= '0;
            r_ox        <= OFS_MIN;
            r_oy        <= OFS_MIN;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_done      <= 1'b0;
            r_pt_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_cx       <= cx;
                        r_cy       <= cy;
                        r_ox       <= OFS_MIN;
                        r_oy       <= OFS_MIN;
                        r_pt_count <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_slot_free) begin
                        if (w_emit) begin
                            r_out_x     <= w_cand_x[COORD_W-1:0];
                            r_out_y     <= w_cand_y[COORD_W-1:0];
                            r_out_valid <= 1'b1;
                            r_pt_count  <= r_pt_count + 6'd1;
                        end else begin
                            r_out_valid <= 1'b0;
                        end
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (r_ox == OFS_MAX) begin
                            r_ox <= OFS_MIN;
                            r_oy <= r_oy + 4'sd1;
                        end else begin
                            r_ox <= r_ox + 4'sd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_slot_free) begin
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign done      = r_done;
    assign pt_count  = r_pt_count;

endmodule
`default_nettype wire
